sky_decode_unit: RTL and testbench
==================================

SKY_DECODE_UNIT -- requirements
Module: sky_decode_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath and operand width.
REQ-002 Parameter NREGS, default 16, architectural register count (power of two); RAW = log2(NREGS).
REQ-003 Parameter IMM_W, default 16, immediate field width; IMM_W < XLEN.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-007 pc_in, instruction  in  XLEN / 32  fetched PC and instruction word.
REQ-008 flush  in  1  squashes the held output and the accepted input this cycle.
REQ-009 rf_read_addr1, rf_read_addr2  out  RAW  equal to rs1 and rs2 of instruction, combinational.
REQ-010 rf_read_data1, rf_read_data2  in  XLEN  register file read data, same cycle.
REQ-011 ex_reg_write, ex_mem_read, ex_rd, ex_data  in  1/1/RAW/XLEN  execute-stage writer; ex_data is invalid when ex_mem_read=1.
REQ-012 wb_reg_write, wb_rd, wb_data  in  1/RAW/XLEN  write-back writer.
REQ-013 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-014 pc_out, operand_a, operand_b, store_data  out  XLEN  registered operands.
REQ-015 rd_addr, alu_op  out  RAW / 4  registered destination and ALU op.
REQ-016 mem_read, mem_write, reg_write, illegal_instr  out  1  registered control flags.

Function
REQ-017 Fields: opcode[31:28], rs1[27:24], rs2[23:20], rd[19:16], funct[15:12], imm[IMM_W-1:0]; register fields zero-extended or truncated to RAW.
REQ-018 Opcode 0 R-type: alu_op=funct, reg_write=1, operand_b=rs2 value.
REQ-019 Opcode 1 I-type: alu_op=funct, reg_write=1, operand_b=sign-extended imm.
REQ-020 Opcode 2 load: alu_op=0, mem_read=1, reg_write=1, operand_b=sign-extended imm.
REQ-021 Opcode 3 store: alu_op=0, mem_write=1, reg_write=0, operand_b=sign-extended imm, store_data=rs2 value.
REQ-022 Opcode 4 LUI: alu_op=0, reg_write=1, operand_a=0, operand_b=imm shifted left by XLEN-IMM_W.
REQ-023 Opcodes 5-15: illegal_instr=1, reg_write/mem_read/mem_write=0, otherwise transferred normally.
REQ-024 reg_write with rd=0 is emitted as reg_write=0; register 0 reads are always 0 regardless of forwarding.
REQ-025 Operand priority per source: r0 -> 0; ex match (ex_reg_write, ex_rd==rs, !ex_mem_read) -> ex_data; wb match -> wb_data; else rf data.
REQ-026 Load-use hazard: ex_mem_read=1, ex_rd!=0, ex_rd equals a used rs -> in_ready=0; a bubble (out_valid=0) is produced if the output register empties.
REQ-027 Used sources: rs1 for opcodes 0-3; rs2 for opcodes 0 and 3 only.
REQ-028 in_ready = !hazard && (!out_valid || out_ready); transfer on in_valid && in_ready; output register loads only on transfer.
REQ-029 out_valid clears when out_ready=1 and no transfer occurs; outputs are held stable while out_valid=1 && out_ready=0.
REQ-030 Latency exactly 1 cycle from input transfer to out_valid; throughput 1 per cycle with no hazards.
REQ-031 flush=1: out_valid<=0 next cycle, the input is not captured, and in_ready is unaffected; flush has priority over transfer.

Reset
REQ-032 reset_n=0 at a clock edge clears out_valid, all control flags, and all data outputs to 0; reset has priority over flush and transfer.
REQ-033 in_ready is 0 while reset_n=0; an instruction in flight is discarded.

Configuration
REQ-034 Macro SKY_DECODE_FWD_EN defined: REQ-025 forwarding is active.
REQ-035 SKY_DECODE_FWD_EN undefined: operands come from rf only; any ex or wb match on a used rs (non-zero) is a hazard per REQ-026, not only loads.

Structure
REQ-036 Package sky_pkg holds the opcode enum, ALU op typedef, and field-position constants; it is shared with execute.
REQ-037 Sub-module sky_fwd_mux is instantiated twice and implements the REQ-025 operand select and hazard-match outputs for one source.

Verification
REQ-038 add r3,r1,r2 with rf r1=5, r2=7, no writers -> operand_a=5, operand_b=7, alu_op=funct, reg_write=1, one cycle later.
REQ-039 I-type with imm=0xFFFF (IMM_W=16) -> operand_b=0xFFFFFFFF; LUI imm=0x1234 -> operand_b=0x12340000, operand_a=0.
REQ-040 ex_reg_write with ex_rd=1, ex_data=0xAA, and wb_rd=1, wb_data=0xBB -> operand_a=0xAA; without SKY_DECODE_FWD_EN, in_ready=0 for that cycle.
REQ-041 Load in ex (ex_mem_read=1, ex_rd=2), decode uses rs2=2 -> in_ready=0 for one cycle, one bubble, then issue with the forwarded value.
REQ-042 out_ready=0 for 3 cycles with out_valid=1 -> outputs constant and in_ready=0; flush mid-stall -> out_valid=0 next cycle.
REQ-043 reset_n=0 while out_valid=1 -> all outputs 0 next edge; opcode 9 -> illegal_instr=1, reg_write=0.

Source files
------------

// File: rtl/sky_pkg.sv
// Shared decode/execute definitions: opcode encoding, ALU op type and instruction field positions.
package sky_pkg;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'd0,
        OP_ITYPE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_STORE = 4'd3,
        OP_LUI   = 4'd4
    } opcode_e;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_PASS = 4'd0;

    localparam int FIELD_W   = 4;
    localparam int OPC_LSB   = 28;
    localparam int RS1_LSB   = 24;
    localparam int RS2_LSB   = 20;
    localparam int RD_LSB    = 16;
    localparam int FUNCT_LSB = 12;

endpackage

// File: rtl/sky_fwd_mux.sv
// Operand select and hazard detection for one register source.
// SKY_DECODE_FWD_EN enables ex/wb forwarding; otherwise any pending writer of the source is a hazard.
module sky_fwd_mux #(
    parameter int XLEN = 32,
    parameter int RAW  = 4
) (
    input  logic [RAW-1:0]  rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [RAW-1:0]  ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            wb_reg_write,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand,
    output logic            hazard
);

    logic rs_nz;
    logic ex_hit;
    logic wb_hit;
    logic load_match;
    logic ex_match;
    logic wb_match;

    assign rs_nz      = |rs;
    assign ex_hit     = rs_nz && (ex_rd == rs);
    assign wb_hit     = rs_nz && (wb_rd == rs);
    assign load_match = ex_hit && ex_mem_read;
    assign ex_match   = ex_hit && ex_reg_write && !ex_mem_read;
    assign wb_match   = wb_hit && wb_reg_write;

`ifdef SKY_DECODE_FWD_EN
    // Execute-stage result is younger than write-back, so it wins.
    always_comb begin
        operand = rf_data;
        if (!rs_nz)
            operand = '0;
        else if (ex_match)
            operand = ex_data;
        else if (wb_match)
            operand = wb_data;
    end

    assign hazard = load_match;
`else
    logic unused_fwd_data;

    assign unused_fwd_data = ^{ex_data, wb_data};
    assign operand = rs_nz ? rf_data : '0;
    assign hazard  = load_match || ex_match || wb_match;
`endif

endmodule

// File: rtl/sky_decode_unit.sv
// Decode stage: field split, operand fetch with hazard stall, registered hand-off to execute.
// Forwarding is enabled by defining SKY_DECODE_FWD_EN (see sky_fwd_mux).
module sky_decode_unit
    import sky_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 16,
    parameter int IMM_W = 16,
    localparam int RAW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instruction,
    input  logic            flush,
    output logic [RAW-1:0]  rf_read_addr1,
    output logic [RAW-1:0]  rf_read_addr2,
    input  logic [XLEN-1:0] rf_read_data1,
    input  logic [XLEN-1:0] rf_read_data2,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [RAW-1:0]  ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            wb_reg_write,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] store_data,
    output logic [RAW-1:0]  rd_addr,
    output logic [3:0]      alu_op,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            illegal_instr
);

    logic [3:0]       opcode;
    alu_op_t          funct;
    logic [RAW-1:0]   rs1;
    logic [RAW-1:0]   rs2;
    logic [RAW-1:0]   rd;
    logic [IMM_W-1:0] imm;
    logic [XLEN-1:0]  imm_sext;
    logic [XLEN-1:0]  imm_lui;

    assign opcode   = instruction[OPC_LSB +: FIELD_W];
    assign funct    = instruction[FUNCT_LSB +: FIELD_W];
    assign rs1      = RAW'(instruction[RS1_LSB +: FIELD_W]);
    assign rs2      = RAW'(instruction[RS2_LSB +: FIELD_W]);
    assign rd       = RAW'(instruction[RD_LSB +: FIELD_W]);
    assign imm      = instruction[IMM_W-1:0];
    assign imm_sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_lui  = {imm, {(XLEN-IMM_W){1'b0}}};

    assign rf_read_addr1 = rs1;
    assign rf_read_addr2 = rs2;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            haz_a;
    logic            haz_b;

    sky_fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_a (
        .rs           (rs1),
        .rf_data      (rf_read_data1),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_data      (ex_data),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .operand      (src_a),
        .hazard       (haz_a)
    );

    sky_fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_b (
        .rs           (rs2),
        .rf_data      (rf_read_data2),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_data      (ex_data),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .operand      (src_b),
        .hazard       (haz_b)
    );

    // Only sources the opcode actually reads may stall the pipe.
    logic uses_rs1;
    logic uses_rs2;
    logic hazard;
    logic transfer;

    assign uses_rs1 = (opcode <= OP_STORE);
    assign uses_rs2 = (opcode == OP_RTYPE) || (opcode == OP_STORE);
    assign hazard   = (uses_rs1 && haz_a) || (uses_rs2 && haz_b);
    assign in_ready = reset_n && !hazard && (!out_valid || out_ready);
    assign transfer = in_valid && in_ready;

    logic [XLEN-1:0] d_a;
    logic [XLEN-1:0] d_b;
    logic [XLEN-1:0] d_store;
    alu_op_t         d_alu;
    logic            d_mem_read;
    logic            d_mem_write;
    logic            d_reg_write;
    logic            d_illegal;

    always_comb begin
        d_a         = src_a;
        d_b         = src_b;
        d_store     = '0;
        d_alu       = funct;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: d_reg_write = 1'b1;
            OP_ITYPE: begin
                d_reg_write = 1'b1;
                d_b         = imm_sext;
            end
            OP_LOAD: begin
                d_alu       = ALU_PASS;
                d_mem_read  = 1'b1;
                d_reg_write = 1'b1;
                d_b         = imm_sext;
            end
            OP_STORE: begin
                d_alu       = ALU_PASS;
                d_mem_write = 1'b1;
                d_b         = imm_sext;
                d_store     = src_b;
            end
            OP_LUI: begin
                d_alu       = ALU_PASS;
                d_reg_write = 1'b1;
                d_a         = '0;
                d_b         = imm_lui;
            end
            default: d_illegal = 1'b1;
        endcase
        if (rd == '0)
            d_reg_write = 1'b0;
    end

    // Flush only kills the valid bit; stale data is harmless once out_valid drops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            pc_out        <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
            store_data    <= '0;
            rd_addr       <= '0;
            alu_op        <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            reg_write     <= 1'b0;
            illegal_instr <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (transfer) begin
            out_valid     <= 1'b1;
            pc_out        <= pc_in;
            operand_a     <= d_a;
            operand_b     <= d_b;
            store_data    <= d_store;
            rd_addr       <= rd;
            alu_op        <= d_alu;
            mem_read      <= d_mem_read;
            mem_write     <= d_mem_write;
            reg_write     <= d_reg_write;
            illegal_instr <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sky_decode_unit.sv
// Self-checking bench for sky_decode_unit: directed scenarios then randomized traffic
// compared cycle by cycle against a behavioural model of the decode rules.
module tb_sky_decode_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in;
    logic [31:0] instruction;
    logic        flush;
    logic [3:0]  rf_read_addr1;
    logic [3:0]  rf_read_addr2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [3:0]  ex_rd;
    logic [31:0] ex_data;
    logic        wb_reg_write;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] store_data;
    logic [3:0]  rd_addr;
    logic [3:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        illegal_instr;

    sky_decode_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pc_in         (pc_in),
        .instruction   (instruction),
        .flush         (flush),
        .rf_read_addr1 (rf_read_addr1),
        .rf_read_addr2 (rf_read_addr2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_rd         (ex_rd),
        .ex_data       (ex_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .pc_out        (pc_out),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .store_data    (store_data),
        .rd_addr       (rd_addr),
        .alu_op        (alu_op),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model of the output register contents.
    logic        mValid;
    logic [31:0] mPc, mA, mB, mSd;
    logic [3:0]  mRd, mAlu;
    logic        mMr, mMw, mRw, mIll;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic rstN, input logic vld, input logic [31:0] instr,
                                 input logic flsh, input logic oRdy,
                                 input logic [31:0] rf1, input logic [31:0] rf2);
        reset_n       = rstN;
        in_valid      = vld;
        instruction   = instr;
        flush         = flsh;
        out_ready     = oRdy;
        rf_read_data1 = rf1;
        rf_read_data2 = rf2;
        pc_in         = pc_in + 32'd4;
    endtask

    task automatic setWriters(input logic exW, input logic exM, input logic [3:0] exRd, input logic [31:0] exD,
                              input logic wbW, input logic [3:0] wbRd, input logic [31:0] wbD);
        ex_reg_write = exW;
        ex_mem_read  = exM;
        ex_rd        = exRd;
        ex_data      = exD;
        wb_reg_write = wbW;
        wb_rd        = wbRd;
        wb_data      = wbD;
    endtask

    function automatic logic [31:0] mkInstr(input logic [3:0] op, input logic [3:0] s1, input logic [3:0] s2,
                                            input logic [3:0] d, input logic [15:0] imm);
        return {op, s1, s2, d, imm};
    endfunction

    // Value a source register should deliver, from the architectural rules.
    function automatic logic [31:0] srcValue(input logic [3:0] rs, input logic [31:0] rf);
        if (rs == 4'd0)
            return 32'd0;
`ifdef SKY_DECODE_FWD_EN
        if (ex_reg_write && !ex_mem_read && ex_rd == rs)
            return ex_data;
        if (wb_reg_write && wb_rd == rs)
            return wb_data;
`endif
        return rf;
    endfunction

    function automatic logic srcHazard(input logic [3:0] rs);
        if (rs == 4'd0)
            return 1'b0;
`ifdef SKY_DECODE_FWD_EN
        return ex_mem_read && ex_rd == rs;
`else
        return ((ex_reg_write || ex_mem_read) && ex_rd == rs) || (wb_reg_write && wb_rd == rs);
`endif
    endfunction

    // One clock: check combinational outputs, advance the model at the edge, check registered outputs.
    task automatic step();
        logic [3:0]  op, fRs1, fRs2, fRd;
        logic [15:0] imm;
        logic [31:0] va, vb, sext;
        logic        used1, used2, haz, expReady;
        #1;
        op   = instruction[31:28];
        fRs1 = instruction[27:24];
        fRs2 = instruction[23:20];
        fRd  = instruction[19:16];
        imm  = instruction[15:0];
        sext = {{16{imm[15]}}, imm};
        va   = srcValue(fRs1, rf_read_data1);
        vb   = srcValue(fRs2, rf_read_data2);
        used1    = (op <= 4'd3);
        used2    = (op == 4'd0) || (op == 4'd3);
        haz      = (used1 && srcHazard(fRs1)) || (used2 && srcHazard(fRs2));
        expReady = reset_n && !haz && (!mValid || out_ready);
        checkOutput("in_ready", in_ready, expReady);
        checkOutput("rf_read_addr1", rf_read_addr1, fRs1);
        checkOutput("rf_read_addr2", rf_read_addr2, fRs2);
        @(posedge clk);
        if (!reset_n) begin
            mValid = 0; mPc = 0; mA = 0; mB = 0; mSd = 0; mRd = 0; mAlu = 0;
            mMr = 0; mMw = 0; mRw = 0; mIll = 0;
        end else if (flush) begin
            mValid = 0;
        end else if (in_valid && expReady) begin
            mValid = 1; mPc = pc_in; mRd = fRd; mA = va; mB = vb; mSd = 0;
            mAlu = imm[15:12]; mMr = 0; mMw = 0; mRw = 0; mIll = 0;
            case (op)
                4'd0: mRw = 1;
                4'd1: begin mRw = 1; mB = sext; end
                4'd2: begin mAlu = 0; mMr = 1; mRw = 1; mB = sext; end
                4'd3: begin mAlu = 0; mMw = 1; mB = sext; mSd = vb; end
                4'd4: begin mAlu = 0; mRw = 1; mA = 0; mB = {imm, 16'h0000}; end
                default: mIll = 1;
            endcase
            if (fRd == 4'd0)
                mRw = 0;
        end else if (out_ready) begin
            mValid = 0;
        end
        #1;
        checkOutput("out_valid", out_valid, mValid);
        checkOutput("pc_out", pc_out, mPc);
        checkOutput("operand_a", operand_a, mA);
        checkOutput("operand_b", operand_b, mB);
        checkOutput("store_data", store_data, mSd);
        checkOutput("rd_addr", rd_addr, mRd);
        checkOutput("alu_op", alu_op, mAlu);
        checkOutput("mem_read", mem_read, mMr);
        checkOutput("mem_write", mem_write, mMw);
        checkOutput("reg_write", reg_write, mRw);
        checkOutput("illegal_instr", illegal_instr, mIll);
        @(negedge clk);
    endtask

    task automatic randomCycle();
        logic [3:0]  op;
        logic [31:0] instr;
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
        instr = mkInstr(op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                        4'($urandom_range(0, 3)), 16'($urandom));
        setWriters(($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 3)), $urandom,
                   ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 3)), $urandom);
        applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0), instr,
                      ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), $urandom, $urandom);
        step();
    endtask

    initial begin
        mValid = 0; mPc = 0; mA = 0; mB = 0; mSd = 0; mRd = 0; mAlu = 0;
        mMr = 0; mMw = 0; mRw = 0; mIll = 0;
        pc_in = 32'h0000_1000;
        setWriters(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, mkInstr(0, 1, 2, 3, 16'h2000), 0, 1, 5, 7);
            step();
        end

        $display("[TB] add r3,r1,r2");
        applyStimulus(1, 1, mkInstr(0, 1, 2, 3, 16'h2000), 0, 1, 32'd5, 32'd7);
        step();
        checkOutput("add_operand_a", operand_a, 32'd5);
        checkOutput("add_operand_b", operand_b, 32'd7);
        checkOutput("add_alu_op", alu_op, 4'd2);
        checkOutput("add_reg_write", reg_write, 1'b1);

        $display("[TB] immediates");
        applyStimulus(1, 1, mkInstr(1, 1, 0, 4, 16'hFFFF), 0, 1, 32'd9, 32'd0);
        step();
        checkOutput("itype_sext", operand_b, 32'hFFFF_FFFF);
        applyStimulus(1, 1, mkInstr(4, 3, 0, 5, 16'h1234), 0, 1, 32'd9, 32'd0);
        step();
        checkOutput("lui_operand_b", operand_b, 32'h1234_0000);
        checkOutput("lui_operand_a", operand_a, 32'd0);

        $display("[TB] ex and wb writers on rs1");
        setWriters(1, 0, 1, 32'hAA, 1, 1, 32'hBB);
        applyStimulus(1, 1, mkInstr(0, 1, 0, 6, 16'h1000), 0, 1, 32'h11, 32'h22);
        step();
        setWriters(0, 0, 0, 0, 0, 0, 0);
        step();

        $display("[TB] load-use on rs2");
        setWriters(0, 1, 2, 32'hDEAD, 0, 0, 0);
        applyStimulus(1, 1, mkInstr(3, 1, 2, 0, 16'h0004), 0, 1, 32'h100, 32'h33);
        step();
        setWriters(0, 0, 0, 0, 1, 2, 32'h77);
        step();
        setWriters(0, 0, 0, 0, 0, 0, 0);
        step();

        $display("[TB] stall and flush");
        applyStimulus(1, 1, mkInstr(0, 1, 2, 7, 16'h3000), 0, 0, 32'h44, 32'h55);
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, mkInstr(1, 2, 0, 8, 16'h0042), 0, 0, 32'h66, 32'h77);
            step();
        end
        applyStimulus(1, 1, mkInstr(1, 2, 0, 8, 16'h0042), 1, 0, 32'h66, 32'h77);
        step();
        checkOutput("flush_out_valid", out_valid, 1'b0);

        $display("[TB] illegal opcode and reset while valid");
        applyStimulus(1, 1, mkInstr(9, 1, 2, 3, 16'h5000), 0, 1, 32'h1, 32'h2);
        step();
        checkOutput("illegal_flag", illegal_instr, 1'b1);
        checkOutput("illegal_reg_write", reg_write, 1'b0);
        applyStimulus(1, 1, mkInstr(2, 1, 0, 3, 16'h0010), 0, 0, 32'h80, 32'h0);
        step();
        applyStimulus(0, 1, mkInstr(2, 1, 0, 3, 16'h0010), 0, 0, 32'h80, 32'h0);
        step();
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_operand_b", operand_b, 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++)
            randomCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
